// File: rtl/mfp_adc_max10_averager_if.sv
// ADC response stream plus averaged-result output stream.
// slave: the averager's view; master: the driver/consumer side (testbench or core).
interface mfp_adc_max10_averager_if #(
   parameter int DW = 12,
   parameter int CW = 3
);
   logic          ADC_R_Valid;
   logic [4:0]    ADC_R_Channel;
   logic [DW-1:0] ADC_R_Data;
   logic          ADC_R_SOP;
   logic          ADC_R_EOP;
   logic          out_valid;
   logic          out_ready;
   logic [4:0]    out_channel;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_count;

   modport slave (
      input  ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP, out_ready,
      output out_valid, out_channel, out_data, out_count
   );

   modport master (
      output ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP, out_ready,
      input  out_valid, out_channel, out_data, out_count
   );
endinterface

// File: rtl/mfp_adc_max10_averager.sv
// Per-channel 2^avg_shift sample averager feeding a small result FIFO.
// Optional packet check: define ADC_AVG_PKT_CHECK_EN to require single-beat
// packets (SOP=EOP=1); otherwise SOP/EOP are ignored and proto_err stays 0.
module mfp_adc_max10_averager #(
   parameter int ADC_DATA_WIDTH = 12,
   parameter int NCH            = 18,
   parameter int MAX_SHIFT      = 7,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          CLK,
   input  logic                          RESET,
   mfp_adc_max10_averager_if.slave       bus,
   input  logic [2:0]                    avg_shift,
   input  logic                          clr_flags,
   output logic                          irq,
   output logic                          overflow,
   output logic                          bad_channel,
   output logic                          proto_err
);
   localparam int DW = ADC_DATA_WIDTH;
   localparam int AW = ADC_DATA_WIDTH + MAX_SHIFT;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [4:0]    ch;
      logic [DW-1:0] data;
   } entry_t;

   logic [AW-1:0]        acc [NCH];
   logic [MAX_SHIFT-1:0] cnt [NCH];
   logic [2:0]           shift_q;
   entry_t               mem [FIFO_DEPTH];
   logic [PW-1:0]        wptr, rptr;
   logic [CW-1:0]        count;

   logic                 shift_chg, ch_ok, pkt_ok, proto_set, accept, last, push;
   logic                 pop, full, do_push, ovf_set;
   logic [AW-1:0]        base_acc, sum;
   logic [MAX_SHIFT-1:0] base_cnt;
   logic [MAX_SHIFT:0]   win;
   logic [DW-1:0]        result;

   // A shift change clears every window; the same-cycle sample sees empty
   // state so it becomes the first sample of the new window.
   always_comb begin
      shift_chg = (avg_shift != shift_q);
      ch_ok     = (bus.ADC_R_Channel < 5'(NCH));
`ifdef ADC_AVG_PKT_CHECK_EN
      pkt_ok    = bus.ADC_R_SOP & bus.ADC_R_EOP;
      proto_set = bus.ADC_R_Valid & ~pkt_ok;
`else
      pkt_ok    = 1'b1;
      proto_set = 1'b0;
`endif
      accept    = bus.ADC_R_Valid & ch_ok & pkt_ok;
      base_acc  = '0;
      base_cnt  = '0;
      if (ch_ok && !shift_chg) begin
         base_acc = acc[bus.ADC_R_Channel];
         base_cnt = cnt[bus.ADC_R_Channel];
      end
      win    = (MAX_SHIFT+1)'(1) << avg_shift;
      last   = ({1'b0, base_cnt} == win - 1'b1);
      sum    = base_acc + AW'(bus.ADC_R_Data);
      result = DW'(sum >> avg_shift);
      push   = accept & last;
   end

   // FIFO control; push while full only lands when a pop frees the slot.
   always_comb begin
      full    = (count == CW'(FIFO_DEPTH));
      pop     = bus.out_valid & bus.out_ready;
      do_push = push & (~full | pop);
      ovf_set = push & full & ~pop;
   end

   // Per-channel accumulators and the registered shift.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         shift_q <= '0;
         for (int c = 0; c < NCH; c++) begin
            acc[c] <= '0;
            cnt[c] <= '0;
         end
      end else begin
         shift_q <= avg_shift;
         if (shift_chg) begin
            for (int c = 0; c < NCH; c++) begin
               acc[c] <= '0;
               cnt[c] <= '0;
            end
         end
         if (accept) begin
            if (last) begin
               acc[bus.ADC_R_Channel] <= '0;
               cnt[bus.ADC_R_Channel] <= '0;
            end else begin
               acc[bus.ADC_R_Channel] <= sum;
               cnt[bus.ADC_R_Channel] <= base_cnt + 1'b1;
            end
         end
      end
   end

   // Result FIFO storage, pointers and occupancy.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= '{ch: bus.ADC_R_Channel, data: result};
            wptr      <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky flags: a set in the same cycle as clr_flags wins.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         overflow    <= 1'b0;
         bad_channel <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         overflow    <= (overflow    & ~clr_flags) | ovf_set;
         bad_channel <= (bad_channel & ~clr_flags) | (bus.ADC_R_Valid & ~ch_ok);
         proto_err   <= (proto_err   & ~clr_flags) | proto_set;
      end
   end

   // Head of FIFO is presented directly from storage.
   always_comb begin
      bus.out_valid   = (count != '0);
      bus.out_channel = mem[rptr].ch;
      bus.out_data    = mem[rptr].data;
      bus.out_count   = count;
      irq             = (count != '0);
   end
endmodule

// File: tb/tb_mfp_adc_max10_averager.sv
// Directed bench for mfp_adc_max10_averager; define ADC_AVG_PKT_CHECK_EN to
// exercise the packet-check build.
module tb_mfp_adc_max10_averager;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [2:0] avg_shift = 3'd0;
   logic       clr_flags = 1'b0;
   logic       irq, overflow, bad_channel, proto_err;
   int         passed = 0;
   int         total = 0;

   mfp_adc_max10_averager_if ifc ();

   mfp_adc_max10_averager dut (
      .CLK(CLK), .RESET(RESET), .bus(ifc), .avg_shift(avg_shift), .clr_flags(clr_flags),
      .irq(irq), .overflow(overflow), .bad_channel(bad_channel), .proto_err(proto_err)
   );

   always #5 CLK = ~CLK;

   // one valid beat spanning exactly one rising edge
   task automatic beat(input logic [4:0] ch, input logic [11:0] d);
      ifc.ADC_R_Valid = 1'b1; ifc.ADC_R_Channel = ch; ifc.ADC_R_Data = d;
      @(negedge CLK);
      ifc.ADC_R_Valid = 1'b0;
   endtask

   task automatic pop1();
      ifc.out_ready = 1'b1;
      @(negedge CLK);
      ifc.out_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      @(negedge CLK);
      clr_flags = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      idle(2);
      RESET = 1'b0;
      total++; if ({ifc.out_valid, irq, overflow, bad_channel, proto_err} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {ifc.out_valid, irq, overflow, bad_channel, proto_err}); else passed++;
      total++; if (ifc.out_count !== 3'd0) $display("FAIL reset_count got %0d want 0", ifc.out_count); else passed++;
      total++; if ({ifc.out_channel, ifc.out_data} !== 17'd0) $display("FAIL reset_head got ch%0d %h want ch0 000", ifc.out_channel, ifc.out_data); else passed++;
   endtask

   task automatic test_passthrough();
      avg_shift = 3'd0;
      beat(5'd3, 12'h123);
      beat(5'd17, 12'hFFF);
      total++; if (ifc.out_count !== 3'd2 || irq !== 1'b1) $display("FAIL pass_count got %0d irq %b want 2 irq 1", ifc.out_count, irq); else passed++;
      total++; if (ifc.out_channel !== 5'd3 || ifc.out_data !== 12'h123) $display("FAIL pass_head0 got ch%0d %h want ch3 123", ifc.out_channel, ifc.out_data); else passed++;
      pop1();
      total++; if (ifc.out_channel !== 5'd17 || ifc.out_data !== 12'hFFF || irq !== 1'b1) $display("FAIL pass_head1 got ch%0d %h irq %b want ch17 fff irq 1", ifc.out_channel, ifc.out_data, irq); else passed++;
      pop1();
      total++; if (ifc.out_count !== 3'd0 || irq !== 1'b0 || ifc.out_valid !== 1'b0) $display("FAIL pass_empty got count %0d irq %b want 0 0", ifc.out_count, irq); else passed++;
   endtask

   task automatic test_avg4();
      avg_shift = 3'd2;
      idle(1);
      beat(5'd5, 12'd10); beat(5'd5, 12'd11); beat(5'd5, 12'd12);
      total++; if (ifc.out_count !== 3'd0) $display("FAIL avg4_early got count %0d want 0", ifc.out_count); else passed++;
      beat(5'd5, 12'd14);
      total++; if (ifc.out_count !== 3'd1 || ifc.out_channel !== 5'd5 || ifc.out_data !== 12'd11) $display("FAIL avg4_result got count %0d ch%0d %0d want 1 ch5 11", ifc.out_count, ifc.out_channel, ifc.out_data); else passed++;
      pop1();
   endtask

   task automatic test_avg128();
      avg_shift = 3'd7;
      idle(1);
      for (int i = 0; i < 128; i++) begin
         beat(5'd0, 12'hFFF);
         if (i < 10) beat(5'd1, 12'd200);
      end
      total++; if (ifc.out_count !== 3'd1 || ifc.out_channel !== 5'd0 || ifc.out_data !== 12'hFFF) $display("FAIL avg128_ch0 got count %0d ch%0d %h want 1 ch0 fff", ifc.out_count, ifc.out_channel, ifc.out_data); else passed++;
      pop1();
      // 10*200 + 118*72 = 10496, /128 = 82
      for (int i = 0; i < 118; i++) beat(5'd1, 12'd72);
      total++; if (ifc.out_count !== 3'd1 || ifc.out_channel !== 5'd1 || ifc.out_data !== 12'd82) $display("FAIL avg128_ch1 got count %0d ch%0d %0d want 1 ch1 82", ifc.out_count, ifc.out_channel, ifc.out_data); else passed++;
      pop1();
   endtask

   task automatic test_overflow();
      avg_shift = 3'd0;
      idle(1);
      for (int i = 0; i < 5; i++) beat(5'(i), 12'(16 + i));
      total++; if (ifc.out_count !== 3'd4 || overflow !== 1'b1) $display("FAIL ovf_full got count %0d ovf %b want 4 1", ifc.out_count, overflow); else passed++;
      total++; if (ifc.out_channel !== 5'd0 || ifc.out_data !== 12'h010) $display("FAIL ovf_head got ch%0d %h want ch0 010", ifc.out_channel, ifc.out_data); else passed++;
      pulse_clr();
      total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
      ifc.out_ready = 1'b1;
      beat(5'd9, 12'h099);
      ifc.out_ready = 1'b0;
      total++; if (ifc.out_count !== 3'd4 || overflow !== 1'b0) $display("FAIL ovf_pushpop got count %0d ovf %b want 4 0", ifc.out_count, overflow); else passed++;
      begin
         logic [4:0]  exp_ch [4] = '{5'd1, 5'd2, 5'd3, 5'd9};
         logic [11:0] exp_d  [4] = '{12'h011, 12'h012, 12'h013, 12'h099};
         for (int i = 0; i < 4; i++) begin
            total++; if (ifc.out_channel !== exp_ch[i] || ifc.out_data !== exp_d[i]) $display("FAIL ovf_order%0d got ch%0d %h want ch%0d %h", i, ifc.out_channel, ifc.out_data, exp_ch[i], exp_d[i]); else passed++;
            pop1();
         end
      end
      total++; if (ifc.out_count !== 3'd0) $display("FAIL ovf_drain got count %0d want 0", ifc.out_count); else passed++;
   endtask

   task automatic test_bad_channel();
      beat(5'd20, 12'h055);
      total++; if (bad_channel !== 1'b1 || ifc.out_count !== 3'd0) $display("FAIL bad_ch got flag %b count %0d want 1 0", bad_channel, ifc.out_count); else passed++;
      pulse_clr();
      total++; if (bad_channel !== 1'b0) $display("FAIL bad_ch_clear got %b want 0", bad_channel); else passed++;
   endtask

   task automatic test_shift_change();
      avg_shift = 3'd2;
      idle(1);
      beat(5'd2, 12'd8); beat(5'd2, 12'd8);
      avg_shift = 3'd3;
      for (int i = 0; i < 7; i++) beat(5'd2, 12'd16);
      total++; if (ifc.out_count !== 3'd0) $display("FAIL shift_early got count %0d want 0", ifc.out_count); else passed++;
      beat(5'd2, 12'd16);
      total++; if (ifc.out_count !== 3'd1 || ifc.out_channel !== 5'd2 || ifc.out_data !== 12'd16) $display("FAIL shift_result got count %0d ch%0d %0d want 1 ch2 16", ifc.out_count, ifc.out_channel, ifc.out_data); else passed++;
      pop1();
   endtask

   task automatic test_proto();
      avg_shift = 3'd0;
      idle(1);
      ifc.ADC_R_SOP = 1'b0;
      beat(5'd4, 12'h0AA);
      ifc.ADC_R_SOP = 1'b1;
`ifdef ADC_AVG_PKT_CHECK_EN
      total++; if (proto_err !== 1'b1 || ifc.out_count !== 3'd0) $display("FAIL proto_drop got err %b count %0d want 1 0", proto_err, ifc.out_count); else passed++;
`else
      total++; if (proto_err !== 1'b0 || ifc.out_count !== 3'd1 || ifc.out_data !== 12'h0AA) $display("FAIL proto_ignore got err %b count %0d %h want 0 1 0aa", proto_err, ifc.out_count, ifc.out_data); else passed++;
`endif
   endtask

   initial begin
      ifc.ADC_R_Valid = 1'b0; ifc.ADC_R_Channel = '0; ifc.ADC_R_Data = '0;
      ifc.ADC_R_SOP = 1'b1; ifc.ADC_R_EOP = 1'b1; ifc.out_ready = 1'b0;
      @(negedge CLK);
      test_reset();
      test_passthrough();
      test_avg4();
      test_avg128();
      test_overflow();
      test_bad_channel();
      test_shift_change();
      test_proto();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
